// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment type, hex decode table and frame layout for seg7_scan.
package seg7_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_OFF = 7'h7F;
    localparam logic [15:0] FRAME_OFF = 16'hFF00;
    localparam int DP_BIT = 15;
    localparam int SEG_LSB = 8;
    localparam int SEL_LSB = 0;
    // Active-low {g,f,e,d,c,b,a}; entry 15 first so HEX_SEG[h] decodes digit h.
    localparam seg_t [15:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/hex2seg.sv
// hex2seg: combinational 4-bit hex to active-low 7-segment decoder.
module hex2seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output seg_t       seg_n_o
);
    assign seg_n_o = HEX_SEG[hex_i];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed 7-segment scanner producing 74HC595 frame words.
// Define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    output logic [15:0] data,
    output logic        s_en
);
    localparam int DIGITS = 4;
    localparam int IW = $clog2(DIGITS);
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]     div_q, div_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [15:0]       val_q, val_d;
    logic [DIGITS-1:0] dp_q, dp_d, blank_q, blank_d;
    logic [15:0]       data_q, data_d;
    logic              s_en_q;
    logic              tick, snap, dark;
    logic [DIGITS-1:0] lz;
    logic [3:0]        hex;
    seg_t              seg_n;
    logic [15:0]       word;

    hex2seg u_hex2seg (
        .hex_i   (hex),
        .seg_n_o (seg_n)
    );

    // The idx-0 tick both advances the scan and uses the fresh snapshot, so inputs bypass the register then.
    always_comb begin
        tick    = div_q == DW'(SCAN_DIV - 1);
        div_d   = tick ? '0 : div_q + DW'(1);
        idx_d   = tick ? idx_q + IW'(1) : idx_q;
        snap    = tick && idx_q == IW'(DIGITS - 1);
        val_d   = snap ? value : val_q;
        dp_d    = snap ? dp : dp_q;
        blank_d = snap ? blank : blank_q;
        hex     = val_d[{idx_d, 2'b00} +: 4];
`ifdef SEG7_SCAN_LZB_EN
        lz[3]   = val_d[15:12] == 4'h0;
        lz[2]   = lz[3] && val_d[11:8] == 4'h0;
        lz[1]   = lz[2] && val_d[7:4] == 4'h0;
        lz[0]   = 1'b0;
`else
        lz      = '0;
`endif
        dark    = blank_d[idx_d] | lz[idx_d];
        word    = '0;
        word[DP_BIT]             = dark | ~dp_d[idx_d];
        word[SEG_LSB +: 7]       = dark ? SEG_OFF : seg_n;
        word[SEL_LSB +: DIGITS]  = DIGITS'(1) << idx_d;
        data_d  = !tick ? data_q : en ? word : FRAME_OFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            idx_q   <= IW'(DIGITS - 1);
            val_q   <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            data_q  <= FRAME_OFF;
            s_en_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            data_q  <= data_d;
            s_en_q  <= tick;
        end
    end

    assign data = data_q;
    assign s_en = s_en_q;
endmodule
